// File: rtl/actuator_cmd_sink.sv
// Actuator command sink: decodes host write words addressed to CTRL_ID and
// drives six actuator outputs with static levels, timed pulses and a
// host-liveness watchdog that de-energises everything when the host goes quiet.
module actuator_cmd_sink #(
  parameter logic [3:0]  CTRL_ID    = 4'b0010,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned WDOG_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_ctrl,
  input  logic [23:0] in_data,
  input  logic        in_wr,
  output logic [5:0]  act_out,
  output logic        busy,
  output logic        wdog_trip,
  output logic        cmd_err
);

  localparam int unsigned PW  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW  = 16;
  localparam int unsigned AW  = 6;

  localparam logic [1:0] OP_SET       = 2'b00;
  localparam logic [1:0] OP_PULSE     = 2'b01;
  localparam logic [1:0] OP_KEEPALIVE = 2'b10;
  localparam logic [1:0] OP_RSVD      = 2'b11;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] WDOG_LAST  = CW'(WDOG_TICKS - 1);
  localparam logic [CW-1:0] WDOG_FULL  = CW'(WDOG_TICKS);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   level_q, level_d;
  logic [AW-1:0]   mask_q, mask_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PW-1:0]   wdiv_q, wdiv_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   act_d;
  logic            busy_d;
  logic            trip_d;
  logic            err_d;

  logic            accept_c;
  logic [1:0]      opcode_c;
  logic [CW-1:0]   width_c;
  logic            presc_tick_c;
  logic            wdiv_tick_c;
  logic            wdog_fire_c;

  assign accept_c     = in_wr && (in_ctrl == CTRL_ID);
  assign opcode_c     = in_data[23:22];
  assign width_c      = in_data[21:6];
  assign presc_tick_c = (state_q == PULSE) && (presc_q == PRESC_LAST);
  assign wdiv_tick_c  = (wdiv_q == PRESC_LAST);
  assign wdog_fire_c  = !accept_c && wdiv_tick_c && (wcnt_q == WDOG_LAST);

  // State and datapath registers; outputs are registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      mask_q      <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
      wdiv_q      <= '0;
      wcnt_q      <= '0;
      act_out     <= '0;
      busy        <= 1'b0;
      wdog_trip   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      wdiv_q      <= wdiv_d;
      wcnt_q      <= wcnt_d;
      act_out     <= act_d;
      busy        <= busy_d;
      wdog_trip   <= trip_d;
      cmd_err     <= err_d;
    end
  end

  // Next state: pulse timing, then watchdog, then accepted command (highest priority)
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    wdiv_d      = wdiv_tick_c ? '0 : wdiv_q + PW'(1);
    wcnt_d      = wcnt_q;
    trip_d      = wdog_trip;
    err_d       = 1'b0;

    if (state_q == PULSE) begin
      if (presc_tick_c) begin
        presc_d     = '0;
        remaining_d = remaining_q - CW'(1);
        if (remaining_q == CW'(1)) begin
          state_d = IDLE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Count stops at the trip value so the watchdog fires only once per silence
    if (wdiv_tick_c && (wcnt_q != WDOG_FULL)) begin
      wcnt_d = wcnt_q + CW'(1);
    end

    if (wdog_fire_c) begin
      level_d = '0;
      state_d = IDLE;
      presc_d = '0;
      trip_d  = 1'b1;
    end

    if (accept_c) begin
      wdiv_d = '0;
      wcnt_d = '0;
      trip_d = 1'b0;
      case (opcode_c)
        OP_SET: level_d = in_data[5:0];
        OP_PULSE: begin
          if (width_c != '0) begin
            mask_d      = in_data[5:0];
            remaining_d = width_c;
            presc_d     = '0;
            state_d     = PULSE;
          end
        end
        OP_KEEPALIVE: ;
        OP_RSVD: err_d = 1'b1;
        default: ;
      endcase
    end

    busy_d = (state_d == PULSE);
    act_d  = level_d | ((state_d == PULSE) ? mask_d : '0);
  end

endmodule
